// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame controller: FSM states,
// pipeline latencies and default survivor-memory geometry.
package viterbi_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int ADDR_DEF  = $clog2(DEPTH_DEF);

  // Branch metric -> path metric -> survivor write.
  localparam int FWD_LAT = 3;
  // RegFile read data arrives this many cycles after the read address.
  localparam int RD_LAT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ACS,
    FLUSH,
    TRACE,
    DONE
  } state_e;

endpackage

// File: rtl/viterbi_stage_pipe.sv
// Forward enable pipeline: one valid bit plus symbol address per stage, so each
// accepted symbol walks through branch metric, path metric and survivor write.
module viterbi_stage_pipe
  import viterbi_pkg::*;
#(
  parameter int ADDR = ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ADDR-1:0]     in_addr,
  output logic [FWD_LAT-1:0]  stage_valid,
  output logic [ADDR-1:0]     wr_addr
);

  logic [FWD_LAT-1:0]           valid_q, valid_d;
  logic [FWD_LAT-1:0][ADDR-1:0] addr_q, addr_d;

  always_comb begin
    valid_d   = {valid_q[FWD_LAT-2:0], in_valid};
    addr_d[0] = in_valid ? in_addr : '0;
    for (int i = 1; i < FWD_LAT; i++) begin
      addr_d[i] = addr_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's old value; blocking here would collapse the shift register.
  // NOTE: the address stages are reset too, since the write address is visible on
  // the shared RegFile port while idle and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign stage_valid = valid_q;
  assign wr_addr     = addr_q[FWD_LAT-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame sequencer: accepts a symbol burst, stages the forward enables,
// then arbitrates the single RegFile port for a descending traceback.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR  = ADDR_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Data_Valid,
  output logic            branch_enable,
  output logic            path_enable,
  output logic            memory_enable,
  output logic            memory_read_enable,
  output logic            trace_enable,
  output logic            tb_first,
  output logic [ADDR-1:0] mem_address,
  output logic            busy,
  output logic            overflow,
  output logic            dropped,
  output logic            Turbo_done
);

  localparam logic [ADDR:0]   DEPTH_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   CNT_ONE   = (ADDR+1)'(1);
  localparam logic [ADDR-1:0] ADDR_ONE  = ADDR'(1);

  state_e             state_q, state_d;
  logic [ADDR:0]      wr_cnt_q, wr_cnt_d;
  logic [ADDR-1:0]    rd_addr_q, rd_addr_d;
  logic               overflow_q, overflow_d;
  logic               dropped_q, dropped_d;
  logic               first_rd_q, first_rd_d;
  logic               turbo_done_q, turbo_done_d;
  logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
  logic [RD_LAT-1:0]  first_pipe_q, first_pipe_d;

  logic               accept;
  logic [ADDR-1:0]    acc_addr;
  logic               rd_en;
  logic [FWD_LAT-1:0] stage_valid;
  logic [ADDR-1:0]    wr_addr;

  viterbi_stage_pipe #(
    .ADDR (ADDR)
  ) u_stage_pipe (
    .clk         (CLK),
    .rst_n       (RST),
    .in_valid    (accept),
    .in_addr     (acc_addr),
    .stage_valid (stage_valid),
    .wr_addr     (wr_addr)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_addr_d    = rd_addr_q;
    overflow_d   = overflow_q;
    dropped_d    = dropped_q;
    first_rd_d   = 1'b0;
    turbo_done_d = 1'b0;
    accept       = 1'b0;
    acc_addr     = wr_cnt_q[ADDR-1:0];
    rd_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          accept     = 1'b1;
          acc_addr   = '0;
          wr_cnt_d   = CNT_ONE;
          overflow_d = 1'b0;
          dropped_d  = 1'b0;
          state_d    = ACS;
        end
      end
      ACS: begin
        // A full memory ends the frame; a symbol arriving then is lost.
        if (wr_cnt_q == DEPTH_CNT) begin
          if (Data_Valid) overflow_d = 1'b1;
          state_d = FLUSH;
        end else if (Data_Valid) begin
          accept   = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (Data_Valid) dropped_d = 1'b1;
        // Only the write stage may still be busy: its last write issues this
        // cycle, so reads start next cycle without sharing the port.
        if (stage_valid[FWD_LAT-2:0] == '0) begin
          state_d    = TRACE;
          rd_addr_d  = wr_cnt_q[ADDR-1:0] - ADDR_ONE;
          first_rd_d = 1'b1;
        end
      end
      TRACE: begin
        if (Data_Valid) dropped_d = 1'b1;
        rd_en = 1'b1;
        if (rd_addr_q == '0) begin
          state_d = DONE;
        end else begin
          rd_addr_d = rd_addr_q - ADDR_ONE;
        end
      end
      DONE: begin
        if (Data_Valid) dropped_d = 1'b1;
        if (turbo_done_q) begin
          state_d = IDLE;
        end else if (trace_enable) begin
          turbo_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_pipe_d    = RD_LAT'({rd_pipe_q, rd_en});
    first_pipe_d = RD_LAT'({first_pipe_q, first_rd_q});
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_addr_q    <= '0;
      overflow_q   <= 1'b0;
      dropped_q    <= 1'b0;
      first_rd_q   <= 1'b0;
      turbo_done_q <= 1'b0;
      rd_pipe_q    <= '0;
      first_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_addr_q    <= rd_addr_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
      first_rd_q   <= first_rd_d;
      turbo_done_q <= turbo_done_d;
      rd_pipe_q    <= rd_pipe_d;
      first_pipe_q <= first_pipe_d;
    end
  end

  assign branch_enable      = stage_valid[0];
  assign path_enable        = stage_valid[1];
  assign memory_enable      = stage_valid[FWD_LAT-1];
  assign memory_read_enable = rd_en;
  assign trace_enable       = rd_pipe_q[RD_LAT-1];
  assign tb_first           = first_pipe_q[RD_LAT-1];
  assign mem_address        = rd_en ? rd_addr_q : wr_addr;
  assign busy               = (state_q != IDLE);
  assign overflow           = overflow_q;
  assign dropped            = dropped_q;
  assign Turbo_done         = turbo_done_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench: directed and random frames compared cycle by cycle
// against a timeline model derived from the frame rules.
module tb_viterbi_frame_ctrl;

  localparam int DEPTH = 64;
  localparam int ADDR  = 6;
  localparam int MAXC  = 2 * DEPTH + 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            Data_Valid = 1'b0;
  logic            branch_enable, path_enable, memory_enable, memory_read_enable;
  logic            trace_enable, tb_first, busy, overflow, dropped, Turbo_done;
  logic [ADDR-1:0] mem_address;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  viterbi_frame_ctrl #(
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .Data_Valid         (Data_Valid),
    .branch_enable      (branch_enable),
    .path_enable        (path_enable),
    .memory_enable      (memory_enable),
    .memory_read_enable (memory_read_enable),
    .trace_enable       (trace_enable),
    .tb_first           (tb_first),
    .mem_address        (mem_address),
    .busy               (busy),
    .overflow           (overflow),
    .dropped            (dropped),
    .Turbo_done         (Turbo_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " branch_enable"},      32'(branch_enable),      0);
    check({pfx, " path_enable"},        32'(path_enable),        0);
    check({pfx, " memory_enable"},      32'(memory_enable),      0);
    check({pfx, " memory_read_enable"}, 32'(memory_read_enable), 0);
    check({pfx, " trace_enable"},       32'(trace_enable),       0);
    check({pfx, " tb_first"},           32'(tb_first),           0);
    check({pfx, " mem_address"},        32'(mem_address),        0);
    check({pfx, " busy"},               32'(busy),               0);
    check({pfx, " overflow"},           32'(overflow),           0);
    check({pfx, " dropped"},            32'(dropped),            0);
    check({pfx, " Turbo_done"},         32'(Turbo_done),         0);
  endtask

  // A frame starts at cycle 0 with the DUT idle. The leading run of r symbols
  // yields n = min(r, DEPTH) accepted symbols; symbol i is written at cycle i+3,
  // the reads fill cycles n+3..2n+2 descending, and Turbo_done lands at 2n+4.
  task automatic run_frame(input int r, input int noise_pct, input int drop_at, input int stop_at);
    bit dv [0:MAXC-1];
    int n, last, e_br, e_pa, e_wr, e_rd, e_te, e_tf, e_td, e_busy, e_addr;
    int e_ovf, e_drop;
    n    = (r > DEPTH) ? DEPTH : r;
    last = 2 * n + 5;
    for (int c = 0; c < MAXC; c++) begin
      if (c < r) dv[c] = 1'b1;
      else if (c > r && c <= 2 * n + 4) dv[c] = ($urandom_range(0, 99) < noise_pct);
      else dv[c] = 1'b0;
    end
    if (drop_at > r && drop_at <= 2 * n + 4) dv[drop_at] = 1'b1;
    e_ovf  = 0;
    e_drop = 0;
    for (int c = 0; c <= last; c++) begin
      if (c == stop_at) begin
        Data_Valid = 1'b0;
        return;
      end
      @(negedge CLK);
      e_br   = int'(c >= 1 && c <= n);
      e_pa   = int'(c >= 2 && c <= n + 1);
      e_wr   = int'(c >= 3 && c <= n + 2);
      e_rd   = int'(c >= n + 3 && c <= 2 * n + 2);
      e_te   = int'(c >= n + 4 && c <= 2 * n + 3);
      e_tf   = int'(c == n + 4);
      e_td   = int'(c == 2 * n + 4);
      e_busy = int'(c >= 1 && c <= 2 * n + 4);
      e_addr = (e_rd != 0) ? (2 * n + 2 - c) : (c - 3);
      check($sformatf("branch_enable c%0d n%0d", c, n), 32'(branch_enable), e_br);
      check($sformatf("path_enable c%0d n%0d", c, n), 32'(path_enable), e_pa);
      check($sformatf("memory_enable c%0d n%0d", c, n), 32'(memory_enable), e_wr);
      check($sformatf("memory_read_enable c%0d n%0d", c, n), 32'(memory_read_enable), e_rd);
      check($sformatf("trace_enable c%0d n%0d", c, n), 32'(trace_enable), e_te);
      check($sformatf("tb_first c%0d n%0d", c, n), 32'(tb_first), e_tf);
      check($sformatf("Turbo_done c%0d n%0d", c, n), 32'(Turbo_done), e_td);
      check($sformatf("busy c%0d n%0d", c, n), 32'(busy), e_busy);
      check($sformatf("port_overlap c%0d", c), 32'(memory_enable && memory_read_enable), 0);
      if (e_rd != 0 || e_wr != 0)
        check($sformatf("mem_address c%0d n%0d", c, n), 32'(mem_address), e_addr);
      if (c >= 1) begin
        if (c - 1 == n && n == DEPTH && dv[n]) e_ovf = 1;
        if (c - 1 >= n + 1 && c - 1 <= 2 * n + 4 && dv[c-1]) e_drop = 1;
        check($sformatf("overflow c%0d n%0d", c, n), 32'(overflow), e_ovf);
        check($sformatf("dropped c%0d n%0d", c, n), 32'(dropped), e_drop);
      end
      Data_Valid = dv[c];
    end
    Data_Valid = 1'b0;
  endtask

  initial begin
    int seen;
    RST = 1'b0;
    Data_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;

    run_frame(4, 0, -1, -1);
    run_frame(DEPTH + 1, 0, -1, -1);
    run_frame(1, 0, -1, -1);
    run_frame(8, 0, 13, -1);
    run_frame(5, 0, -1, -1);

    // Abort mid-traceback: outputs must drop before any clock edge.
    run_frame(10, 0, -1, 16);
    @(negedge CLK);
    check("pre_reset read active", 32'(memory_read_enable), 1);
    #2 RST = 1'b0;
    #1 check_all_zero("async_reset");
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      seen += 32'(Turbo_done);
    end
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      seen += 32'(Turbo_done);
    end
    check("Turbo_done after abort", seen, 0);
    run_frame(3, 0, -1, -1);

    for (int k = 0; k < 10; k++) begin
      run_frame($urandom_range(1, DEPTH + 2), 10, -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
